// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and assembles 32-bit instructions from four byte reads.
// Optional build macro IF_MISALIGN_CHK_EN aligns redirect targets and flags misaligned ones.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        dclk,
   input  logic        rst,
   input  logic [1:0]  stl_STALLER_i,
   input  logic        br_en_EX_i,
   input  logic [31:0] br_tgt_EX_i,
   input  logic        mem_gnt_MCTL_i,
   input  logic        mem_valid_MCTL_i,
   input  logic [7:0]  mem_data_MCTL_i,
   output logic        mem_rd_MCTL_o,
   output logic [31:0] mem_addr_MCTL_o,
   output logic [31:0] inst_IFID_o,
   output logic [31:0] pc_IFID_o,
   output logic        stlreq_STALLER_o
`ifdef IF_MISALIGN_CHK_EN
   ,
   output logic        misalign_EXC_o
`endif
);

   typedef enum logic {FETCH = 1'b0, DONE = 1'b1} state_t;

   localparam logic [1:0] STL_RUN = 2'b00;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [1:0]  r_cnt;
   logic [31:0] r_buf;
   logic        r_pend;

   state_t      w_state_next;
   logic [31:0] w_pc_next;
   logic [1:0]  w_cnt_next;
   logic [31:0] w_buf_next;
   logic        w_pend_next;
   logic [31:0] w_tgt;
   logic        w_capture;

`ifdef IF_MISALIGN_CHK_EN
   logic r_misalign;
   assign w_tgt          = {br_tgt_EX_i[31:2], 2'b00};
   assign misalign_EXC_o = r_misalign;
`else
   assign w_tgt = br_tgt_EX_i;
`endif

   // A byte is accepted only against a granted request, so stale returns after reset/redirect are ignored.
   assign w_capture = (r_state == FETCH) && mem_valid_MCTL_i && (mem_gnt_MCTL_i || r_pend);

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_cnt_next   = r_cnt;
      w_buf_next   = r_buf;
      w_pend_next  = r_pend;
      case (r_state)
         FETCH: begin
            if (w_capture) begin
               w_buf_next[8*r_cnt +: 8] = mem_data_MCTL_i;
               w_pend_next              = 1'b0;
               if (r_cnt == 2'd3) begin
                  w_state_next = DONE;
                  w_cnt_next   = 2'd0;
               end else begin
                  w_cnt_next = r_cnt + 2'd1;
               end
            end else if (mem_gnt_MCTL_i) begin
               w_pend_next = 1'b1;
            end
         end
         DONE: begin
            if (stl_STALLER_i == STL_RUN) begin
               w_pc_next    = r_pc + 32'd4;
               w_state_next = FETCH;
            end
         end
         default: w_state_next = FETCH;
      endcase
      // Redirect overrides stall and any byte returned in the same cycle.
      if (br_en_EX_i) begin
         w_pc_next    = w_tgt;
         w_cnt_next   = 2'd0;
         w_state_next = FETCH;
         w_buf_next   = 32'h0;
         w_pend_next  = 1'b0;
      end
   end

   always_ff @(posedge dclk) begin
      if (rst) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_cnt   <= 2'd0;
         r_buf   <= 32'h0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_cnt   <= w_cnt_next;
         r_buf   <= w_buf_next;
         r_pend  <= w_pend_next;
      end
   end

`ifdef IF_MISALIGN_CHK_EN
   always_ff @(posedge dclk) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= br_en_EX_i && (br_tgt_EX_i[1:0] != 2'b00);
      end
   end
`endif

   assign mem_rd_MCTL_o    = (r_state == FETCH) && !rst;
   assign mem_addr_MCTL_o  = ((r_state == FETCH) && !rst) ? (r_pc + {30'd0, r_cnt}) : 32'h0;
   assign stlreq_STALLER_o = (r_state == FETCH) || rst;
   assign inst_IFID_o      = ((r_state == DONE) && !rst) ? r_buf : 32'h0;
   assign pc_IFID_o        = ((r_state == DONE) && !rst) ? r_pc  : 32'h0;

endmodule
